uart_mmio_master: RTL and testbench



---
 rtl/uart_mmio_master.sv | 151 +++++++++++++++
 tb/tb_uart_mmio_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_master.sv
// rtl/uart_mmio_master.sv - UART-framed command decoder issuing 32-bit MMIO reads/writes and byte replies.
// Optional inter-byte timeout enabled by defining UART_MST_TIMEOUT_EN.
module uart_mmio_master #(
  parameter logic [7:0] ACK_BYTE       = 8'h4B,
  parameter logic [7:0] NAK_BYTE       = 8'h3F,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         TO_BITS        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        active,
  output logic        err_timeout
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, LOAD_TX, TX_PULSE, TX_WAIT
  } state_t;

  state_t      state, state_nx;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [2:0]  resp_cnt;
  logic [31:0] resp_sr;
  logic        timeout_hit;

`ifdef UART_MST_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt;
  logic               err_q;

  assign timeout_hit = (state == GET_ADDR || state == GET_DATA) && !rx_valid &&
                       (to_cnt == TO_BITS'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if ((state == GET_ADDR || state == GET_DATA) && !rx_valid && !timeout_hit)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign bus_en   = (state == BUS);
  assign bus_we   = (state == BUS) && is_write;
  assign tx_start = (state == TX_PULSE);
  assign active   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (rx_valid)
          state_nx = (rx_data == CMD_WRITE || rx_data == CMD_READ) ? GET_ADDR : LOAD_TX;
      GET_ADDR:
        if (timeout_hit)
          state_nx = IDLE;
        else if (rx_valid && byte_cnt == 2'd3)
          state_nx = is_write ? GET_DATA : BUS;
      GET_DATA:
        if (timeout_hit)
          state_nx = IDLE;
        else if (rx_valid && byte_cnt == 2'd3)
          state_nx = BUS;
      BUS:      state_nx = LOAD_TX;
      LOAD_TX:  if (!tx_busy) state_nx = TX_PULSE;
      TX_PULSE: state_nx = TX_WAIT;
      TX_WAIT:  state_nx = (resp_cnt > 3'd1) ? LOAD_TX : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Replies always leave from resp_sr[31:24]; single-byte replies are parked there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write  <= 1'b0;
      byte_cnt  <= 2'd0;
      resp_cnt  <= 3'd0;
      resp_sr   <= 32'd0;
      tx_data   <= 8'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE:
          if (rx_valid) begin
            is_write <= (rx_data == CMD_WRITE);
            byte_cnt <= 2'd0;
            if (rx_data != CMD_WRITE && rx_data != CMD_READ) begin
              resp_sr  <= {NAK_BYTE, 24'd0};
              resp_cnt <= 3'd1;
            end
          end
        GET_ADDR:
          if (rx_valid && !timeout_hit) begin
            bus_addr <= {bus_addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        GET_DATA:
          if (rx_valid && !timeout_hit) begin
            bus_wdata <= {bus_wdata[23:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        BUS:
          if (is_write) begin
            resp_sr  <= {ACK_BYTE, 24'd0};
            resp_cnt <= 3'd1;
          end else begin
            resp_sr  <= bus_rdata;
            resp_cnt <= 3'd4;
          end
        LOAD_TX:
          if (!tx_busy) tx_data <= resp_sr[31:24];
        TX_WAIT:
          if (resp_cnt > 3'd1) begin
            resp_sr  <= {resp_sr[23:0], 8'd0};
            resp_cnt <= resp_cnt - 3'd1;
          end else begin
            resp_cnt <= 3'd0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_master.sv
// tb/tb_uart_mmio_master.sv - randomized self-checking bench for uart_mmio_master against a frame-level model.
module tb_uart_mmio_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        bus_en;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        active;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem [16];
  logic [3:0]  busy_cnt;
  bus_t        mon_bus;
  logic [7:0]  mon_tx;

  uart_mmio_master #(
    .ACK_BYTE(8'h4B), .NAK_BYTE(8'h3F), .TIMEOUT_CYCLES(100), .TO_BITS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Simple uart_tx stand-in: goes busy the cycle after tx_start for a random time.
  always @(posedge clk) begin
    if (!rst_n)         busy_cnt <= 4'd0;
    else if (tx_start)  busy_cnt <= 4'($urandom_range(1, 8));
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 4'd0);

  assign bus_rdata = slave_mem[bus_addr[5:2]];
  always @(posedge clk) if (bus_en && bus_we) slave_mem[bus_addr[5:2]] <= bus_wdata;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_en) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          mon_bus = exp_bus.pop_front();
          chk("bus_we", bus_we, mon_bus.we);
          chk("bus_addr", bus_addr, mon_bus.addr);
          if (mon_bus.we) chk("bus_wdata", bus_wdata, mon_bus.wdata);
        end
      end
      if (tx_start) begin
        chk("tx_busy_at_start", tx_busy, 0);
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          mon_tx = exp_tx.pop_front();
          chk("tx_data", tx_data, mon_tx);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      if (i != 0) gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int max_gap);
    exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    exp_tx.push_back(8'h4B);
    ref_mem[a[5:2]] = d;
    send_byte(8'h57);
    gap($urandom_range(0, max_gap));
    send_word(a, max_gap);
    gap($urandom_range(0, max_gap));
    send_word(d, max_gap);
  endtask

  task automatic do_read(input logic [31:0] a, input int max_gap);
    logic [31:0] r;
    r = ref_mem[a[5:2]];
    exp_bus.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
    send_byte(8'h52);
    gap($urandom_range(0, max_gap));
    send_word(a, max_gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active || tx_busy) && n < 2000) begin gap(1); n++; end
    if (n >= 2000) chk("idle_timeout", 1, 0);
    gap(1);
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    int          pulses;

    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[9] = 32'h0000_0005;
    ref_mem[9]   = 32'h0000_0005;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    gap(3);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_active", active, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rst_n = 1'b1;
    gap(2);

    // Directed write with latency checks
    do_write(32'h1000_0020, 32'h0000_0041, 0);
    chk("lat_rx_to_bus", bus_en, 1);
    gap(2);
    chk("lat_bus_to_tx", tx_start, 1);
    wait_idle();

    do_read(32'h1000_0024, 0);
    wait_idle();

    // Unknown command then a normal read
    exp_tx.push_back(8'h3F);
    send_byte(8'h33);
    wait_idle();
    do_read(32'h1000_0024, 2);
    wait_idle();

    // A byte arriving in TX_WAIT must be dropped
    do_write(32'h0000_0008, 32'hCAFE_F00D, 1);
    begin
      int n;
      n = 0;
      while (!tx_start && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("drop_wait_tx", 1, 0);
    end
    @(posedge clk); #1;
    send_byte(8'h57);
    gap(3);
    chk("drop_active", active, 0);
    wait_idle();

    // Asynchronous reset mid-frame
    send_byte(8'h52);
    send_byte(8'h10);
    send_byte(8'h00);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", bus_addr, 0);
    chk("async_rst_active", active, 0);
    gap(2);
    rst_n = 1'b1;
    gap(1);
    do_read(32'h1000_0024, 1);
    wait_idle();

`ifdef UART_MST_TIMEOUT_EN
    pulses = 0;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (120) begin @(negedge clk); if (err_timeout) pulses++; end
    chk("timeout_pulses", pulses, 1);
    chk("timeout_active", active, 0);
    gap(1);
    do_write(32'h0000_0010, 32'h1234_5678, 1);
    wait_idle();
`else
    pulses = 0;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (120) begin @(negedge clk); if (err_timeout) pulses++; end
    chk("no_timeout_pulses", pulses, 0);
    chk("no_timeout_active", active, 1);
    gap(1);
    rst_n = 1'b0; gap(1); rst_n = 1'b1; gap(1);
`endif

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 3);
        1: do_read(a, 3);
        default: begin
          do c = 8'($urandom_range(0, 255)); while (c == 8'h57 || c == 8'h52);
          exp_tx.push_back(8'h3F);
          send_byte(c);
        end
      endcase
      wait_idle();
    end

    chk("bus_pending", exp_bus.size(), 0);
    chk("tx_pending", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
